// File: rtl/rv32i_pipe_pkg.sv
// rv32i_pipe_pkg: shared constants, FSM state encodings and sizing helper for the IF/ID stall controller
package rv32i_pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSHED = 2'd2;
  typedef enum logic [1:0] {
    RUN = ST_RUN,
    STALL = ST_STALL,
    FLUSHED = ST_FLUSHED
  } state_e;
  function automatic int run_len_w(input int max_stall);
    return $clog2(max_stall + 2);
  endfunction
endpackage

// File: rtl/if_id_stall_ctrl_watchdog.sv
// stall_watchdog: counts consecutive stall cycles and raises a sticky deadlock flag when a stall outlives MAX_STALL_CYCLES
module stall_watchdog
  import rv32i_pipe_pkg::*;
#(
  parameter int MAX_STALL_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  input  logic i_flush,
  output logic o_deadlock
);
  localparam int RW = run_len_w(MAX_STALL_CYCLES);
  localparam logic [RW-1:0] LIM = RW'(MAX_STALL_CYCLES);
  localparam logic [RW-1:0] SAT = RW'(MAX_STALL_CYCLES + 1);
  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run_nxt;
  logic          r_deadlock;
  // run length grows only on a real (unflushed) stall and saturates one past the limit
  always_comb
    w_run_nxt = (i_stall & ~i_flush) ? ((r_run == SAT) ? r_run : r_run + RW'(1)) : '0;
  // run-length register and sticky deadlock flag; only reset clears the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= '0;
      r_deadlock <= 1'b0;
    end else begin
      r_run <= w_run_nxt;
      if ((r_run == LIM) && i_stall) r_deadlock <= 1'b1;
    end
  end
  assign o_deadlock = r_deadlock;
endmodule

// File: rtl/if_id_stall_ctrl.sv
// if_id_stall_ctrl: IF/ID register with hazard stall, bubble injection and branch flush; perf counters under STALL_PERF_EN
module if_id_stall_ctrl
  import rv32i_pipe_pkg::*;
#(
  parameter int XLEN             = XLEN_DEF,
  parameter int MAX_STALL_CYCLES = 3,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_F,
  input  logic [XLEN-1:0]  instr_F,
  input  logic             stall_D,
  input  logic             flush_E,
  output logic             pc_en_F,
  output logic [XLEN-1:0]  pc_D,
  output logic [XLEN-1:0]  instr_D,
  output logic             valid_D,
  output logic             bubble_E,
  output logic             deadlock_err,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;
  logic            w_stall_eff;
  logic            w_stall_cnt_en;
  assign w_stall_eff    = stall_D & r_valid & (r_state != FLUSHED);
  assign w_stall_cnt_en = w_stall_eff & ~flush_E;
  assign pc_en_F        = flush_E | ~w_stall_eff;
  assign bubble_E       = flush_E | w_stall_eff;
  assign pc_D           = r_pc;
  assign instr_D        = r_instr;
  assign valid_D        = r_valid;
  // IF/ID register: flush kills, stall holds, otherwise capture the fetched instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= XLEN'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (flush_E) begin
      r_pc    <= pc_F;
      r_instr <= XLEN'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (!w_stall_eff) begin
      r_pc    <= pc_F;
      r_instr <= instr_F;
      r_valid <= 1'b1;
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end
  // FSM next state: flush dominates; the unused encoding falls back to RUN
  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RUN:     w_state_nxt = flush_E ? FLUSHED : (w_stall_eff ? STALL : RUN);
      STALL:   w_state_nxt = flush_E ? FLUSHED : (w_stall_eff ? STALL : RUN);
      FLUSHED: w_state_nxt = flush_E ? FLUSHED : RUN;
      default: w_state_nxt = RUN;
    endcase
  end
  stall_watchdog #(
    .MAX_STALL_CYCLES(MAX_STALL_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_stall   (w_stall_eff),
    .i_flush   (flush_E),
    .o_deadlock(deadlock_err)
  );
`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  // free-running perf counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_cnt_en) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_E)        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  logic w_unused;
  assign w_unused    = w_stall_cnt_en;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule
